// File: rtl/control_sequencer.sv
// control_sequencer: fetch (T0-T2) then one register-register ALU instruction (T3-T5).
// Rev 1.0
`default_nettype none

module control_sequencer #(
   parameter int NUM_REGS    = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [31:0]            IR,
   output logic                   PCout,
   output logic                   ZLOout,
   output logic                   MDRout,
   output logic                   MARin,
   output logic                   Zin,
   output logic                   PCin,
   output logic                   MDRin,
   output logic                   IRin,
   output logic                   Yin,
   output logic                   IncrementPC,
   output logic                   Read,
   output logic [4:0]             ALUControl,
   output logic [NUM_REGS-1:0]    Rin,
   output logic [NUM_REGS-1:0]    Rout,
   output logic                   Busy,
   output logic                   Done,
   output logic                   Illegal,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_ILL  = 3'd7
   } state_t;

   state_t              state;
   logic [3:0]          ra;
   logic [3:0]          rc;
   logic [NUM_REGS-1:0] rout_q;

   logic [4:0] ir_opcode;
   logic [3:0] ir_ra;
   logic [3:0] ir_rb;
   logic [3:0] ir_rc;
   logic       ir_legal;
   logic [4:0] ir_alu;
   logic       unused_ir_bits;

   // Returns {supported, alu_select} for an opcode.
   function automatic logic [5:0] decode_op(input logic [4:0] op);
      case (op)
         5'b00011: decode_op = {1'b1, 5'b00000};  // add
         5'b00100: decode_op = {1'b1, 5'b00010};  // sub
         5'b00101: decode_op = {1'b1, 5'b00001};  // and
         5'b00110: decode_op = {1'b1, 5'b00011};  // or
         5'b00111: decode_op = {1'b1, 5'b00100};  // shr
         5'b01001: decode_op = {1'b1, 5'b00101};  // shl
         5'b01010: decode_op = {1'b1, 5'b00110};  // ror
         5'b01011: decode_op = {1'b1, 5'b00111};  // rol
         default:  decode_op = 6'b0;
      endcase
   endfunction

   function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
      onehot = NUM_REGS'(1) << idx;
   endfunction

   assign ir_opcode = IR[31:27];
   assign ir_ra     = IR[26:23];
   assign ir_rb     = IR[22:19];
   assign ir_rc     = IR[18:15];
   assign {ir_legal, ir_alu} = decode_op(ir_opcode);
   assign unused_ir_bits = ^IR[14:0];

   // IR only becomes valid on the edge entering T3, so the T3 operand drive
   // cannot be registered and is decoded live from IR.
   assign Yin  = (state == S_T3) && ir_legal;
   assign Rout = ((state == S_T3) && ir_legal) ? onehot(ir_rb) : rout_q;

   // Output registers are loaded with the values of the state being entered.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= S_IDLE;
         ra          <= 4'd0;
         rc          <= 4'd0;
         rout_q      <= '0;
         PCout       <= 1'b0;
         ZLOout      <= 1'b0;
         MDRout      <= 1'b0;
         MARin       <= 1'b0;
         Zin         <= 1'b0;
         PCin        <= 1'b0;
         MDRin       <= 1'b0;
         IRin        <= 1'b0;
         IncrementPC <= 1'b0;
         Read        <= 1'b0;
         ALUControl  <= 5'b00000;
         Rin         <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Illegal     <= 1'b0;
         InstrCount  <= '0;
      end else begin
         PCout       <= 1'b0;
         ZLOout      <= 1'b0;
         MDRout      <= 1'b0;
         MARin       <= 1'b0;
         Zin         <= 1'b0;
         PCin        <= 1'b0;
         MDRin       <= 1'b0;
         IRin        <= 1'b0;
         IncrementPC <= 1'b0;
         Read        <= 1'b0;
         ALUControl  <= 5'b00000;
         Rin         <= '0;
         rout_q      <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Illegal     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (Start) begin
                  state <= S_T0;
                  PCout <= 1'b1;
                  MARin <= 1'b1;
                  Zin   <= 1'b1;
                  Busy  <= 1'b1;
               end
            end
            S_T0: begin
               state       <= S_T1;
               ZLOout      <= 1'b1;
               PCin        <= 1'b1;
               IncrementPC <= 1'b1;
               Read        <= 1'b1;
               MDRin       <= 1'b1;
               Busy        <= 1'b1;
            end
            S_T1: begin
               state  <= S_T2;
               MDRout <= 1'b1;
               IRin   <= 1'b1;
               Busy   <= 1'b1;
            end
            S_T2: begin
               state <= S_T3;
               Busy  <= 1'b1;
            end
            S_T3: begin
               ra   <= ir_ra;
               rc   <= ir_rc;
               Busy <= 1'b1;
               if (ir_legal) begin
                  state      <= S_T4;
                  rout_q     <= onehot(ir_rc);
                  ALUControl <= ir_alu;
                  Zin        <= 1'b1;
               end else begin
                  state   <= S_ILL;
                  Illegal <= 1'b1;
               end
            end
            S_T4: begin
               state  <= S_T5;
               ZLOout <= 1'b1;
               Rin    <= onehot(ra);
               Done   <= 1'b1;
               Busy   <= 1'b1;
            end
            S_T5: begin
               InstrCount <= InstrCount + COUNT_WIDTH'(1);
               if (Start) begin
                  state <= S_T0;
                  PCout <= 1'b1;
                  MARin <= 1'b1;
                  Zin   <= 1'b1;
                  Busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_ILL: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control rows from a table-driven model.
// Rev 1.0
`default_nettype none

module tb_control_sequencer;

   localparam int NR = 16;
   localparam int CW = 4;

   typedef struct packed {
      logic          pcout;
      logic          zloout;
      logic          mdrout;
      logic          marin;
      logic          zin;
      logic          pcin;
      logic          mdrin;
      logic          irin;
      logic          yin;
      logic          incpc;
      logic          read;
      logic [4:0]    alu;
      logic [NR-1:0] rin;
      logic [NR-1:0] rout;
      logic          busy;
      logic          done;
      logic          illegal;
      logic [CW-1:0] cnt;
   } row_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   ir;
   logic          PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC, Read;
   logic [4:0]    ALUControl;
   logic [NR-1:0] Rin, Rout;
   logic          Busy, Done, Illegal;
   logic [CW-1:0] InstrCount;

   int   checks   = 0;
   int   failures = 0;
   int   cnt      = 0;
   bit   chk_en   = 1'b0;
   row_t exp_q[$];

   bit [4:0] legal_ops [8];
   bit [4:0] alu_codes [8];
   bit [4:0] alu_map [bit [4:0]];

   always #5 clk = ~clk;

   control_sequencer #(.NUM_REGS(NR), .COUNT_WIDTH(CW)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .IR(ir),
      .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
      .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncrementPC(IncrementPC),
      .Read(Read), .ALUControl(ALUControl), .Rin(Rin), .Rout(Rout),
      .Busy(Busy), .Done(Done), .Illegal(Illegal), .InstrCount(InstrCount)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic row_t busy_row();
      row_t r = '0;
      r.busy = 1'b1;
      r.cnt  = CW'(cnt);
      return r;
   endfunction

   task automatic push_idle();
      row_t r = '0;
      r.cnt = CW'(cnt);
      exp_q.push_back(r);
   endtask

   // Expected cycle-by-cycle rows for one instruction, starting at T0.
   task automatic push_instr(input logic [31:0] instr);
      row_t r;
      bit [4:0] op = instr[31:27];
      bit legal = alu_map.exists(op);
      r = busy_row(); r.pcout = 1; r.marin = 1; r.zin = 1; exp_q.push_back(r);
      r = busy_row(); r.zloout = 1; r.pcin = 1; r.incpc = 1; r.read = 1; r.mdrin = 1; exp_q.push_back(r);
      r = busy_row(); r.mdrout = 1; r.irin = 1; exp_q.push_back(r);
      r = busy_row();
      if (legal) begin r.rout = NR'(1) << instr[22:19]; r.yin = 1; end
      exp_q.push_back(r);
      if (legal) begin
         r = busy_row(); r.rout = NR'(1) << instr[18:15]; r.alu = alu_map[op]; r.zin = 1; exp_q.push_back(r);
         r = busy_row(); r.zloout = 1; r.rin = NR'(1) << instr[26:23]; r.done = 1; exp_q.push_back(r);
         cnt = (cnt + 1) % (1 << CW);
      end else begin
         r = busy_row(); r.illegal = 1; exp_q.push_back(r);
      end
   endtask

   task automatic idle_cycles(input int gap);
      repeat (gap) begin
         push_idle();
         start = 1'b0;
         tick();
      end
      push_idle();
   endtask

   // Called in an IDLE or T5 cycle; returns with in_t5=1 if left in T5 with Start high.
   task automatic run_instr(input logic [31:0] instr, input bit chain, input bit do_rst,
                            output bit in_t5);
      bit legal = alu_map.exists(instr[31:27]);
      in_t5 = 1'b0;
      push_instr(instr);
      start = 1'b1; ir = $urandom;
      tick();                                   // T0
      start = 1'($urandom); ir = $urandom;
      tick();                                   // T1
      start = 1'($urandom); ir = $urandom;
      tick();                                   // T2
      start = 1'($urandom); ir = instr;
      tick();                                   // T3
      start = 1'($urandom);
      tick();                                   // T4 or ILL
      ir = $urandom;
      start = 1'($urandom);
      if (!legal) begin
         tick();                                // IDLE
         return;
      end
      if (do_rst) begin
         rst = 1'b1;
         @(negedge clk);
         #1;
         exp_q.delete();
         cnt = 0;
         tick();                                // IDLE after reset
         rst = 1'b0;
         return;
      end
      tick();                                   // T5
      start = chain;
      if (chain) in_t5 = 1'b1;
      else tick();                              // IDLE
   endtask

   function automatic logic [31:0] rand_legal();
      return {legal_ops[$urandom_range(0, 7)], 27'($urandom)};
   endfunction

   // Monitor: every checked cycle pops one expected row.
   row_t act, e;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            act = '{PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC, Read,
                    ALUControl, Rin, Rout, Busy, Done, Illegal, InstrCount};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_cycle t=%0t actual=%h required=<no expected row>", $time, act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  failures++;
                  $display("FAIL cycle_row t=%0t actual=%h required=%h", $time, act, e);
               end
            end
         end
      end
   end

   initial begin
      bit in_t5;
      logic [31:0] instr;
      legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01010, 5'b01011};
      alu_codes = '{5'b00000, 5'b00010, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111};
      for (int i = 0; i < 8; i++) alu_map[legal_ops[i]] = alu_codes[i];

      rst = 1'b1; start = 1'b1; ir = 32'h0;
      tick();
      tick();
      rst = 1'b0; start = 1'b0;
      chk_en = 1'b1;

      idle_cycles(1);
      run_instr(32'h28918000, 1'b0, 1'b0, in_t5);        // and R1,R2,R3

      idle_cycles(0);                                      // three chained add R4,R4,R5
      run_instr(32'h1A228000, 1'b1, 1'b0, in_t5);
      run_instr(32'h1A228000, 1'b1, 1'b0, in_t5);
      run_instr(32'h1A228000, 1'b0, 1'b0, in_t5);

      idle_cycles(2);                                      // unsupported opcode
      run_instr({5'b11111, 27'($urandom)}, 1'b0, 1'b0, in_t5);

      idle_cycles(0);                                      // reset during T4
      run_instr(rand_legal(), 1'b0, 1'b1, in_t5);

      idle_cycles(1);                                      // 17 chained: counter wraps
      for (int k = 0; k < 17; k++) run_instr(rand_legal(), k != 16, 1'b0, in_t5);

      in_t5 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!in_t5) idle_cycles($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) instr = $urandom;
         else instr = rand_legal();
         run_instr(instr, (k != 39) && ($urandom_range(0, 3) != 0), 1'b0, in_t5);
      end

      push_idle();
      start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drained actual=%0d rows left required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
